// File: rtl/cleaning_display_scan.sv
// cleaning_display_scan: frame-synchronous 3-digit 7-segment scanner with leading-zero blanking, dash for invalid BCD and blink.
module cleaning_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic       blink_en,
  output logic [2:0] an,
  output logic [6:0] seg
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);
  logic [PW-1:0] pre;
  logic [FW-1:0] fc;
  logic [1:0] idx;
  logic [3:0] h0, h1, h2, cur;
  logic blink_phase, tick, frame, blank1, blank2, off;
  logic [2:0] an_n;
  logic [6:0] seg_n, dec;
  always_comb begin
    tick = pre == PMAX;
    frame = tick && idx == 2'd2;
    blank2 = h2 == 4'd0;
    blank1 = blank2 && h1 == 4'd0;
    cur = idx == 2'd0 ? h0 : idx == 2'd1 ? h1 : h2;
    case (cur)
      4'd0: dec = 7'h01;
      4'd1: dec = 7'h4F;
      4'd2: dec = 7'h12;
      4'd3: dec = 7'h06;
      4'd4: dec = 7'h4C;
      4'd5: dec = 7'h24;
      4'd6: dec = 7'h20;
      4'd7: dec = 7'h0F;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h04;
      default: dec = 7'h7E;
    endcase
    off = (idx == 2'd2 && blank2) || (idx == 2'd1 && blank1) || (blink_en && blink_phase);
    an_n = off ? 3'b111 : ~(3'b001 << idx);
    seg_n = off ? 7'h7F : dec;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
      fc <= '0;
      blink_phase <= 1'b0;
      an <= 3'b111;
      seg <= 7'h7F;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
      if (frame) begin
        h0 <= digit0;
        h1 <= digit1;
        h2 <= digit2;
        fc <= fc == FMAX ? '0 : fc + 1'b1;
        if (fc == FMAX) blink_phase <= ~blink_phase;
      end
      an <= an_n;
      seg <= seg_n;
    end
  end
endmodule

// File: tb/tb_cleaning_display_scan.sv
// tb_cleaning_display_scan: randomized and directed scenarios against a cycle-count reference model.
module tb_cleaning_display_scan;
  localparam int R = 4;
  localparam int BF = 2;
  logic clk = 0, reset = 1, blink_en = 0;
  logic [3:0] digit0 = 0, digit1 = 0, digit2 = 0;
  logic [2:0] an;
  logic [6:0] seg;
  int pass = 0, total = 0, n = 0;
  logic [3:0] mh [3];
  logic [2:0] ea;
  logic [6:0] es;

  cleaning_display_scan #(.REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .blink_en(blink_en), .an(an), .seg(seg));

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] t [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    return d > 9 ? 7'h7E : t[d];
  endfunction

  // Model: state before the n-th post-reset edge follows from n alone plus the digits held at the last boundary.
  task automatic cyc();
    int slot, frm;
    bit blank;
    @(posedge clk);
    if (reset) begin
      n = 0;
      mh = '{default: 4'd0};
      ea = 3'b111;
      es = 7'h7F;
    end else begin
      slot = (n / R) % 3;
      frm = n / (3 * R);
      blank = (slot == 2 && mh[2] == 0) || (slot == 1 && mh[2] == 0 && mh[1] == 0)
              || (blink_en && ((frm / BF) % 2 == 1));
      ea = blank ? 3'b111 : ~(3'b001 << slot);
      es = blank ? 7'h7F : dec7(mh[slot]);
      if (n % (3 * R) == 3 * R - 1) mh = '{digit0, digit1, digit2};
      n++;
    end
    #1;
  endtask

  task automatic set_d(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    @(negedge clk);
    digit2 = d2;
    digit1 = d1;
    digit0 = d0;
  endtask

  task automatic test_reset();
    set_d(9, 9, 9);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (an !== 3'b111 || seg !== 7'h7F) $display("FAIL reset an=%b seg=%h want 111/7f", an, seg);
      else pass++;
    end
    @(negedge clk) reset = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (an !== 3'b110 || seg !== 7'h01) $display("FAIL reset_release an=%b seg=%h want 110/01", an, seg);
      else pass++;
    end
    for (int i = 4; i < 12; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL pre_boundary n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
  endtask

  task automatic test_frame();
    set_d(1, 2, 0);
    for (int i = 0; i < 36; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL frame n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
      if (n % 12 == 5) begin
        @(negedge clk);
        digit0 = 4'd7;
        digit1 = 4'd8;
      end
    end
  endtask

  task automatic test_leading_zero();
    set_d(0, 0, 5);
    for (int i = 0; i < 36; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL lz_005 n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
    set_d(0, 3, 0);
    for (int i = 0; i < 36; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL lz_030 n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
  endtask

  task automatic test_invalid();
    set_d(0, 4'hC, 4'hF);
    for (int i = 0; i < 36; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL invalid n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
  endtask

  task automatic test_blink();
    set_d(1, 2, 0);
    blink_en = 1;
    for (int i = 0; i < 110; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL blink n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
    @(negedge clk) blink_en = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL blink_off n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
  endtask

  task automatic test_reset_mid();
    set_d(4, 5, 6);
    for (int g = 0; g < 40 && !(n % 12 == 5); g++) cyc();
    @(negedge clk) reset = 1;
    cyc();
    total++;
    if (an !== 3'b111 || seg !== 7'h7F) $display("FAIL reset_mid an=%b seg=%h want 111/7f", an, seg);
    else pass++;
    @(negedge clk) reset = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL reset_resume n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        digit0 = 4'($urandom_range(0, 15));
        digit1 = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
        digit2 = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
      reset = $urandom_range(0, 299) == 0;
      cyc();
      total++;
      if (an !== ea || seg !== es) $display("FAIL random n=%0d an=%b/%b seg=%h/%h", n, an, ea, seg, es);
      else pass++;
    end
    @(negedge clk) reset = 0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_leading_zero();
    test_invalid();
    test_blink();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
